tcdm_burst_reader: RTL and testbench

Strided read master that sits directly upstream of the TCDM memory slave: it accepts a burst command (base address, word count, byte stride), issues one TCDM read per word while honouring `gnt`, and collects the in-order `r_valid` responses into a small FIFO. The FIFO drains as a valid/ready word stream toward the SpMM datapath. The block issues a read only when FIFO space is guaranteed, so responses are never dropped under downstream back-pressure or memory stalls.

---
 rtl/tcdm_burst_reader_pkg.sv | 21 ++
 rtl/hwpe_stream_intf_tcdm.sv | 14 +
 rtl/tcdm_burst_reader_fifo.sv | 54 +++++
 rtl/tcdm_burst_reader.sv | 131 +++++++++++++
 tb/tb_tcdm_burst_reader.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/tcdm_burst_reader_pkg.sv
// Shared types and widths for the strided TCDM burst reader.
package tcdm_burst_reader_pkg;

  localparam int unsigned TCDM_AW   = 32;
  localparam int unsigned TCDM_DW   = 32;
  // The command length field is held at the widest supported LEN_W (<= 32).
  localparam int unsigned CMD_LEN_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic [TCDM_AW-1:0]   addr;
    logic [CMD_LEN_W-1:0] len;
    logic [TCDM_AW-1:0]   stride;
  } cmd_t;

endpackage

// File: rtl/hwpe_stream_intf_tcdm.sv
// TCDM request/response bundle between a read master and the memory slave.
interface hwpe_stream_intf_tcdm;
  logic        req;
  logic        gnt;
  logic [31:0] add;
  logic        wen;
  logic [3:0]  be;
  logic [31:0] data;
  logic [31:0] r_data;
  logic        r_valid;

  modport master (output req, add, wen, be, data, input gnt, r_data, r_valid);
  modport slave  (input req, add, wen, be, data, output gnt, r_data, r_valid);
endinterface

// File: rtl/tcdm_burst_reader_fifo.sv
// Small synchronous FIFO buffering read responses; head is read straight from storage.
module tcdm_burst_reader_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 32,
  localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [DW-1:0] data_i,
  input  logic          pop_i,
  output logic [DW-1:0] data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Storage is cleared on reset so the head reads zero while empty.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wptr_q] <= data_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PW'(1);
      if (do_pop)  rptr_q <= rptr_q + PW'(1);
      if (do_push && !do_pop)      count_q <= count_q + CW'(1);
      else if (do_pop && !do_push) count_q <= count_q - CW'(1);
    end
  end

endmodule

// File: rtl/tcdm_burst_reader.sv
// Strided TCDM read master: issues one read per word only when FIFO space is
// guaranteed, and streams the in-order responses out as valid/ready words.
module tcdm_burst_reader
  import tcdm_burst_reader_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LEN_W      = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic [TCDM_AW-1:0] cmd_addr_i,
  input  logic [LEN_W-1:0]   cmd_len_i,
  input  logic [TCDM_AW-1:0] cmd_stride_i,
  hwpe_stream_intf_tcdm.master tcdm,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [TCDM_DW-1:0] out_data_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  state_e        state_q;
  cmd_t          cmd_q;      // addr = next address to request, len = words left to issue
  logic          req_q;
  logic          done_q;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] fifo_count, fifo_count_d;
  logic          fifo_empty, fifo_full;
  logic          grant, rsp_push, fifo_push, out_pop, last_grant, credit_ok;

  assign grant      = req_q && tcdm.gnt;
  // Responses with nothing outstanding are stale (e.g. from before a reset).
  assign rsp_push   = tcdm.r_valid && (outst_q != '0);
  assign fifo_push  = rsp_push && !fifo_full;
  assign out_pop    = out_valid_o && out_ready_i;
  assign last_grant = grant && (cmd_q.len == CMD_LEN_W'(1));

  // Next-cycle occupancy of outstanding reads and of the FIFO.
  always_comb begin
    outst_d      = outst_q;
    fifo_count_d = fifo_count;
    if (grant && !rsp_push)      outst_d = outst_q + CW'(1);
    else if (rsp_push && !grant) outst_d = outst_q - CW'(1);
    if (fifo_push && !out_pop)      fifo_count_d = fifo_count + CW'(1);
    else if (out_pop && !fifo_push) fifo_count_d = fifo_count - CW'(1);
  end

  // A new request may be raised only if every in-flight word has a FIFO slot.
  assign credit_ok = ({1'b0, outst_d} + {1'b0, fifo_count_d}) < (CW + 1)'(FIFO_DEPTH);

  // Control FSM with registered req/add/done.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      outst_q <= '0;
    end else begin
      done_q  <= 1'b0;
      outst_q <= outst_d;
      case (state_q)
        IDLE: begin
          if (cmd_valid_i) begin
            if (cmd_len_i == '0) begin
              done_q <= 1'b1;
            end else begin
              // Nothing is in flight in IDLE, so the first request needs no credit check.
              cmd_q   <= '{addr: cmd_addr_i, len: CMD_LEN_W'(cmd_len_i), stride: cmd_stride_i};
              req_q   <= 1'b1;
              state_q <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (grant) begin
            cmd_q.addr <= cmd_q.addr + cmd_q.stride;
            cmd_q.len  <= cmd_q.len - CMD_LEN_W'(1);
            if (last_grant) begin
              req_q   <= 1'b0;
              state_q <= DRAIN;
            end else begin
              req_q <= credit_ok;
            end
          end else if (!req_q) begin
            // A raised request is held until granted; only raising is gated.
            req_q <= credit_ok;
          end
        end
        DRAIN: begin
          if (out_pop && (outst_q == '0) && (fifo_count == CW'(1))) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  tcdm_burst_reader_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (TCDM_DW)
  ) i_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push),
    .data_i  (tcdm.r_data),
    .pop_i   (out_pop),
    .data_o  (out_data_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign cmd_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;
  assign out_valid_o = !fifo_empty;

  assign tcdm.req  = req_q;
  assign tcdm.add  = cmd_q.addr;
  assign tcdm.wen  = 1'b1;
  assign tcdm.be   = 4'hF;
  assign tcdm.data = '0;

endmodule

// File: tb/tb_tcdm_burst_reader.sv
// Scoreboard bench: stimulus queues expected addresses/words, a negedge process
// models the memory slave and consumer and checks everything the DUT presents.
module tb_tcdm_burst_reader;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_addr = '0;
  logic [15:0] cmd_len = '0;
  logic [31:0] cmd_stride = '0;
  logic        out_valid, out_ready, busy, done;
  logic [31:0] out_data;

  always #5 clk = ~clk;

  hwpe_stream_intf_tcdm tcdm_if ();

  tcdm_burst_reader #(.FIFO_DEPTH(4), .LEN_W(16)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_addr_i   (cmd_addr),
    .cmd_len_i    (cmd_len),
    .cmd_stride_i (cmd_stride),
    .tcdm         (tcdm_if),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_data_o   (out_data),
    .busy_o       (busy),
    .done_o       (done)
  );

  typedef struct {
    int          due;
    logic [31:0] data;
  } rsp_t;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int lat = 1;
  int gnt_mode = 0;    // 0: always grant, 1: random stalls
  int ready_mode = 0;  // 0: always ready, 1: held off, 2: random
  int grant_cnt = 0, pop_cnt = 0, done_cnt = 0;
  int first_grant_cyc = 0, first_pop_cyc = 0, last_event_cyc = 0, cmd_cyc = 0;
  logic        hold_pend = 1'b0;
  logic [31:0] hold_add = '0;
  rsp_t        rsp_q[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];

  // Memory contents: word at 0x100 + 4*i holds i.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a >> 2) - 32'h40;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Memory slave, stall/hold checker and output consumer, all at the negedge.
  always @(negedge clk) begin
    cyc++;
    if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
      tcdm_if.r_valid = 1'b1;
      tcdm_if.r_data  = rsp_q[0].data;
      void'(rsp_q.pop_front());
    end else begin
      tcdm_if.r_valid = 1'b0;
      tcdm_if.r_data  = 32'hDEAD_BEEF;
    end

    if (hold_pend && rst_ni)
      check("req_add_hold", {31'd0, tcdm_if.req, tcdm_if.add}, {31'd0, 1'b1, hold_add});

    tcdm_if.gnt = (gnt_mode == 1) ? 1'($urandom_range(1)) : 1'b1;
    hold_pend = tcdm_if.req && !tcdm_if.gnt && rst_ni;
    hold_add  = tcdm_if.add;
    if (tcdm_if.req && tcdm_if.gnt && rst_ni) begin
      grant_cnt++;
      if (grant_cnt == 1) first_grant_cyc = cyc;
      if (exp_addr_q.size() == 0) check("unexpected_req", 64'(tcdm_if.add), 64'hFFFF_FFFF_FFFF_FFFF);
      else check("req_addr", 64'(tcdm_if.add), 64'(exp_addr_q.pop_front()));
      check("tcdm_wen_be_data", {27'd0, tcdm_if.wen, tcdm_if.be, tcdm_if.data}, {27'd0, 1'b1, 4'hF, 32'd0});
      rsp_q.push_back('{due: cyc + lat, data: mem_word(tcdm_if.add)});
    end

    out_ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? 1'b0 : 1'($urandom_range(1));
    if (done && rst_ni) begin
      done_cnt++;
      check("done_timing", 64'(cyc), 64'(last_event_cyc + 1));
    end
    if (out_valid && out_ready && rst_ni) begin
      pop_cnt++;
      if (pop_cnt == 1) first_pop_cyc = cyc;
      last_event_cyc = cyc;
      if (exp_data_q.size() == 0) check("unexpected_word", 64'(out_data), 64'hFFFF_FFFF_FFFF_FFFF);
      else check("out_data", 64'(out_data), 64'(exp_data_q.pop_front()));
    end
  end

  task automatic issue(input logic [31:0] a, input logic [15:0] n, input logic [31:0] s);
    logic [31:0] ad;
    for (int k = 0; k < int'(n); k++) begin
      ad = a + s * 32'(k);
      exp_addr_q.push_back(ad);
      exp_data_q.push_back(mem_word(ad));
    end
    @(negedge clk); #1;
    grant_cnt = 0;
    pop_cnt = 0;
    check("cmd_ready", 64'(cmd_ready), 64'd1);
    cmd_valid  = 1'b1;
    cmd_addr   = a;
    cmd_len    = n;
    cmd_stride = s;
    cmd_cyc    = cyc;
    if (n == 0) last_event_cyc = cyc;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int start;
    int k;
    start = done_cnt;
    k = 0;
    while (done_cnt == start && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    repeat (3) begin @(negedge clk); #1; end
    check("done_pulses", 64'(done_cnt - start), 64'd1);
    check("busy_after", 64'(busy), 64'd0);
    check("queues_empty", 64'(exp_data_q.size() + exp_addr_q.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    // Reset values
    @(negedge clk); #1;
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_busy_done_valid", {61'd0, busy, done, out_valid}, 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_req_add", {31'd0, tcdm_if.req, tcdm_if.add}, 64'd0);
    check("rst_wen_be_data", {27'd0, tcdm_if.wen, tcdm_if.be, tcdm_if.data}, {27'd0, 1'b1, 4'hF, 32'd0});
    @(posedge clk); #2 rst_ni = 1'b1;

    // Basic burst: 0x100, len 8, stride 4, no stalls
    lat = 1; gnt_mode = 0; ready_mode = 0;
    issue(32'h100, 16'd8, 32'd4);
    wait_done(100);
    check("basic_first_req_cycle", 64'(first_grant_cyc), 64'(cmd_cyc + 1));
    check("basic_first_word_cycle", 64'(first_pop_cyc), 64'(cmd_cyc + 3));
    check("basic_last_word_cycle", 64'(last_event_cyc), 64'(cmd_cyc + 10));
    check("basic_grants", 64'(grant_cnt), 64'd8);

    // Memory stalls plus random consumer readiness: len 16, stride 8
    lat = 2; gnt_mode = 1; ready_mode = 2;
    issue(32'h2000, 16'd16, 32'd8);
    wait_done(600);
    check("stall_words", 64'(pop_cnt), 64'd16);
    gnt_mode = 0; ready_mode = 0;

    // Back-pressure: consumer held off for 20 cycles, len 10
    lat = 1; ready_mode = 1;
    issue(32'h300, 16'd10, 32'd4);
    repeat (20) begin @(negedge clk); #1; end
    check("bp_grants_capped", 64'(grant_cnt), 64'd4);
    check("bp_req_low", 64'(tcdm_if.req), 64'd0);
    check("bp_no_words", 64'(pop_cnt), 64'd0);
    ready_mode = 0;
    wait_done(100);
    check("bp_words", 64'(pop_cnt), 64'd10);

    // Zero-length command: no request, done one cycle later
    issue(32'h40, 16'd0, 32'd4);
    wait_done(10);
    check("len0_no_req", 64'(grant_cnt), 64'd0);

    // Negative stride wrapping below zero: 0x4, 0x0, 0xFFFFFFFC
    issue(32'h4, 16'd3, 32'hFFFF_FFFC);
    wait_done(50);
    check("wrap_grants", 64'(grant_cnt), 64'd3);

    // Reset after 3 grants of a len-8 burst, then a fresh len-2 burst
    lat = 3;
    issue(32'h500, 16'd8, 32'd4);
    k = 0;
    while (grant_cnt < 3 && k < 50) begin @(negedge clk); #1; k++; end
    check("rst_mid_grants_seen", 64'(grant_cnt), 64'd3);
    @(posedge clk); #2 rst_ni = 1'b0;
    #1;
    check("rst_mid_req_drop", 64'(tcdm_if.req), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    exp_addr_q.delete();
    exp_data_q.delete();
    @(negedge clk); #1;
    @(negedge clk); #1 rst_ni = 1'b1;
    k = 0;
    while (rsp_q.size() > 0 && k < 20) begin @(negedge clk); #1; k++; end
    @(negedge clk); #1;
    check("stale_rsp_ignored", 64'(out_valid), 64'd0);
    issue(32'h600, 16'd2, 32'd4);
    wait_done(50);
    check("post_rst_words", 64'(pop_cnt), 64'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
